ngy_grid_scanout: RTL
=====================

// Module: ngy_grid_scanout
// PURPOSE
//  Reader end of the snake grid bitmap: scans the GRID_ROWS x GRID_COLS cell bitmap out as 320x240 video.
//  - Generates pixel timing, expands each cell to a CELL_SIZE x CELL_SIZE square and emits RGB/HS/VS/DE.
//  - Sits between the game logic (writer of grid_ram) and the Pocket video output.
//  - Latches the bitmap once per frame at vblank start so a frame never tears mid-scan.
// PARAMETERS
//  GRID_ROWS   30        cell rows
//  GRID_COLS   40        cell columns
//  RAM_LENGTH  1200      bitmap bits; must equal GRID_ROWS*GRID_COLS
//  CELL_LOG2   3         log2 of cell edge in pixels (8 px cells -> 320x240 active)
//  PIX_DIV     12        clk_74a cycles per pixel; pix_ce asserts once every PIX_DIV cycles
//  H_FP/H_SYNC/H_BP  10/10/60  horizontal porch/sync widths in pixels (H_TOTAL 400)
//  V_FP/V_SYNC/V_BP   2/2/18   vertical porch/sync widths in lines (V_TOTAL 262)
//  FG_RGB      24'h00FF00  colour of a set cell
//  BG_RGB      24'h000000  colour of a clear cell
// PORTS
//  clk_74a     in   1           single clock for the whole block
//  reset_n     in   1           synchronous active-low reset
//  grid_ram    in   [0:RAM_LENGTH-1]  cell bitmap, index = row*GRID_COLS+col, bit 1 = cell lit
//  pix_ce      out  1           pixel clock enable; 1-cycle pulse every PIX_DIV clk_74a cycles
//  video_rgb   out  24          pixel colour {R,G,B}, 8 bits each
//  video_de    out  1           active-video qualifier
//  video_hs    out  1           horizontal sync, active high
//  video_vs    out  1           vertical sync, active high
//  frame_done  out  1           1-cycle pulse when the bitmap snapshot is taken (vblank start)
// BEHAVIOUR
//  - Reset is synchronous, active-low. All outputs reset to 0; divider, hcnt, vcnt reset to 0; snapshot reset to all 0.
//  - Reset mid-frame: next cycle after release restarts at hcnt=0, vcnt=0 with a blank snapshot.
//  - Divider counts 0..PIX_DIV-1 and wraps; pix_ce=1 on the cycle the count equals PIX_DIV-1.
//  - hcnt 0..H_TOTAL-1 advances on pix_ce; at wrap vcnt advances, 0..V_TOTAL-1 then back to 0.
//  - Active region: hcnt<320 && vcnt<240. HS=1 for hcnt in [320+H_FP, 320+H_FP+H_SYNC); VS=1 likewise on vcnt.
//  - Snapshot: on the pix_ce where hcnt==0 && vcnt==240, shadow<=grid_ram and frame_done pulses that same cycle.
//    grid_ram changes at any other time have no visible effect until the next snapshot.
//  - Scan pipeline, advanced only on pix_ce, 2 pixel ticks total latency:
//    S1: idx <= (vcnt>>CELL_LOG2)*GRID_COLS + (hcnt>>CELL_LOG2) (11 bits); de/hs/vs delayed one tick.
//    S2: video_rgb <= de ? (shadow[idx] ? FG_RGB : BG_RGB) : 0; de/hs/vs delayed a second tick.
//  - video_de, video_hs, video_vs and video_rgb stay mutually aligned; outputs hold between pix_ce pulses.
//  - idx is only used while de=1, so it never exceeds RAM_LENGTH-1; blanking forces rgb to 24'h000000.
//  - A snapshot tick always falls in blanking, so the S1/S2 reads never observe a half-updated shadow.
// CONFIGURATION
//  - Macro NGY_GRID_LINES_EN:
//    - Defined: a pixel whose in-cell x or y offset is 0 and whose cell is clear outputs 24'h202020 (grid lines).
//    - Undefined: clear cells are uniformly BG_RGB.
//    - Latency and sync timing are identical either way.
// STRUCTURE
//  - Shared header ngy_video_defs.vh:
//    - localparams: 320x240 active size, porch/sync defaults, H_TOTAL/V_TOTAL
//    - colour constants: FG, BG, grid-line grey
//  - Sub-module ngy_video_timing: divider, hcnt/vcnt, raw de/hs/vs, and the snapshot strobe.
//  - Top holds the shadow register, the S1/S2 pipeline and the grid-line option.
// TESTING
//  - Reset: hold reset_n=0 for 5 cycles -> all outputs 0; first pix_ce comes exactly PIX_DIV cycles after release.
//  - Timing: run 2 frames -> 262 VS-delimited lines of 400 pixels each; 320 de pixels per active line; HS width 10 px; VS 2 lines.
//  - Mapping: set only grid_ram[41] (row1,col1) -> rgb=FG exactly for hcnt 8..15, vcnt 8..15 (2 ticks later); all else BG.
//  - Corner: set grid_ram[1199] -> FG at pixels x 312..319, y 232..239; no FG appears in blanking.
//  - Tear-free: toggle grid_ram[0] mid-active-frame -> output unchanged until after the next frame_done.
//  - Option: with NGY_GRID_LINES_EN and an all-0 grid -> pixel (0,0)=24'h202020, pixel (1,1)=BG_RGB.

Source files
------------

// File: rtl/ngy_grid_scanout_pkg.sv
// Shared constants and types for the grid bitmap scan-out path.
// Default geometry is 320x240 active out of a 400x262 raster.
package ngy_grid_scanout_pkg;

  localparam int unsigned H_ACTIVE   = 320;
  localparam int unsigned V_ACTIVE   = 240;
  localparam int unsigned H_FP_DEF   = 10;
  localparam int unsigned H_SYNC_DEF = 10;
  localparam int unsigned H_BP_DEF   = 60;
  localparam int unsigned V_FP_DEF   = 2;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 18;
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Wide enough for either raster counter at the default geometry.
  localparam int unsigned CNT_W = 10;

  localparam logic [23:0] FG_RGB_DEF = 24'h00FF00;
  localparam logic [23:0] BG_RGB_DEF = 24'h000000;
  localparam logic [23:0] GRID_RGB   = 24'h202020;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic in_window(logic [CNT_W-1:0] cnt, int unsigned lo, int unsigned len);
    return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/ngy_grid_scanout_if.sv
// Video output bundle of the grid scan-out: pixel strobe, colour, sync and frame marker.
interface ngy_grid_scanout_if;

  logic        pix_ce;
  logic [23:0] video_rgb;
  logic        video_de;
  logic        video_hs;
  logic        video_vs;
  logic        frame_done;

  modport master (
    output pix_ce,
    output video_rgb,
    output video_de,
    output video_hs,
    output video_vs,
    output frame_done
  );

  modport slave (
    input pix_ce,
    input video_rgb,
    input video_de,
    input video_hs,
    input video_vs,
    input frame_done
  );

endinterface

// File: rtl/ngy_grid_scanout_timing.sv
// Raster timing: pixel divider, h/v counters, raw de/hs/vs and the vblank snapshot strobe.
module ngy_grid_scanout_timing
  import ngy_grid_scanout_pkg::*;
#(
  parameter int unsigned PIX_DIV = 12,
  parameter int unsigned H_ACT   = H_ACTIVE,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_ACT   = V_ACTIVE,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF
) (
  input  logic             clk_74a,
  input  logic             reset_n,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output sync_t            sync,
  output logic             snap
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] vcnt_q;

  assign pix_ce = (div_q == DIV_W'(PIX_DIV - 1));

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q <= pix_ce ? '0 : div_q + 1'b1;
      if (pix_ce) begin
        if (hcnt_q == CNT_W'(H_TOT - 1)) begin
          hcnt_q <= '0;
          vcnt_q <= (vcnt_q == CNT_W'(V_TOT - 1)) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_q <= hcnt_q + 1'b1;
        end
      end
    end
  end

  assign hcnt    = hcnt_q;
  assign vcnt    = vcnt_q;
  assign sync.de = (32'(hcnt_q) < H_ACT) && (32'(vcnt_q) < V_ACT);
  assign sync.hs = in_window(hcnt_q, H_ACT + H_FP, H_SYNC);
  assign sync.vs = in_window(vcnt_q, V_ACT + V_FP, V_SYNC);

  // First blanking pixel of the frame: the bitmap is not being read here.
  assign snap = pix_ce && (hcnt_q == '0) && (vcnt_q == CNT_W'(V_ACT));

endmodule

// File: rtl/ngy_grid_scanout.sv
// Grid bitmap scan-out: snapshots grid_ram at vblank and expands each cell into a pixel square.
// Optional NGY_GRID_LINES_EN draws grey grid lines on the top/left edge of clear cells.
module ngy_grid_scanout
  import ngy_grid_scanout_pkg::*;
#(
  parameter int unsigned GRID_ROWS  = 30,
  parameter int unsigned GRID_COLS  = 40,
  parameter int unsigned RAM_LENGTH = 1200,
  parameter int unsigned CELL_LOG2  = 3,
  parameter int unsigned PIX_DIV    = 12,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter logic [23:0] FG_RGB     = FG_RGB_DEF,
  parameter logic [23:0] BG_RGB     = BG_RGB_DEF
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  input  logic [0:RAM_LENGTH-1] grid_ram,
  ngy_grid_scanout_if.master    video
);

  localparam int unsigned H_ACT = GRID_COLS << CELL_LOG2;
  localparam int unsigned V_ACT = GRID_ROWS << CELL_LOG2;
  localparam int unsigned IDX_W = $clog2(RAM_LENGTH);

  logic                  pix_ce;
  logic                  snap;
  logic [CNT_W-1:0]      hcnt;
  logic [CNT_W-1:0]      vcnt;
  sync_t                 sync_raw;
  sync_t                 sync_s1_q;
  sync_t                 sync_s2_q;
  logic [0:RAM_LENGTH-1] shadow_q;
  logic [IDX_W-1:0]      idx_q;
  logic [23:0]           rgb_d;
  logic [23:0]           rgb_q;

  ngy_grid_scanout_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk_74a (clk_74a),
    .reset_n (reset_n),
    .pix_ce  (pix_ce),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .sync    (sync_raw),
    .snap    (snap)
  );

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      shadow_q <= '0;
    end else if (snap) begin
      shadow_q <= grid_ram;
    end
  end

`ifdef NGY_GRID_LINES_EN
  localparam int unsigned CELL_MASK = (1 << CELL_LOG2) - 1;
  logic line_s1_q;

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      line_s1_q <= 1'b0;
    end else if (pix_ce) begin
      line_s1_q <= ((32'(hcnt) & CELL_MASK) == 0) || ((32'(vcnt) & CELL_MASK) == 0);
    end
  end
`endif

  // S2 colour lookup; blanking always forces black regardless of the bitmap.
  always_comb begin
    rgb_d = '0;
    if (sync_s1_q.de) begin
      if (shadow_q[idx_q]) begin
        rgb_d = FG_RGB;
`ifdef NGY_GRID_LINES_EN
      end else if (line_s1_q) begin
        rgb_d = GRID_RGB;
`endif
      end else begin
        rgb_d = BG_RGB;
      end
    end
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      idx_q     <= '0;
      sync_s1_q <= '0;
      sync_s2_q <= '0;
      rgb_q     <= '0;
    end else if (pix_ce) begin
      idx_q     <= IDX_W'(((32'(vcnt) >> CELL_LOG2) * GRID_COLS) + (32'(hcnt) >> CELL_LOG2));
      sync_s1_q <= sync_raw;
      sync_s2_q <= sync_s1_q;
      rgb_q     <= rgb_d;
    end
  end

  assign video.pix_ce     = pix_ce;
  assign video.video_rgb  = rgb_q;
  assign video.video_de   = sync_s2_q.de;
  assign video.video_hs   = sync_s2_q.hs;
  assign video.video_vs   = sync_s2_q.vs;
  assign video.frame_done = snap;

endmodule
